// File: rtl/idle_setup_ctrl.sv
// idle_setup_ctrl: debounced start handshake that captures mode/level/speed settings
// and holds them for a consumer until acknowledged.
module idle_setup_ctrl #(
    parameter int MODE_W     = 2,
    parameter int LEVEL_W    = 2,
    parameter int SPEED_W    = 2,
    parameter int START_HOLD = 4,
    parameter int MAX_LEVEL  = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_start,
    input  logic [MODE_W-1:0]  i_mode,
    input  logic [LEVEL_W-1:0] i_level,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic               i_ack,
    output logic               o_active,
    output logic               o_ready,
    output logic               o_done,
    output logic [MODE_W-1:0]  o_mode,
    output logic [LEVEL_W-1:0] o_level,
    output logic [SPEED_W-1:0] o_speed,
    output logic               o_err
);
    localparam int CNT_W = $clog2(START_HOLD + 1);
    localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(MAX_LEVEL);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(START_HOLD - 1);

    typedef enum logic [2:0] {IDLE, ARMED, HOLD, DONE, RELEASE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             capture;

    // Final start-high sample: either the single-sample case from ARMED or the last HOLD count.
    always_comb capture = i_enable && i_start &&
                          ((state == ARMED && START_HOLD == 1) || (state == HOLD && cnt == LAST));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            o_active <= 1'b0;
            o_ready  <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            o_mode   <= '0;
            o_level  <= '0;
            o_speed  <= '0;
        end else begin
            o_done <= 1'b0;
            if (!i_enable) begin
                state    <= IDLE;
                cnt      <= '0;
                o_active <= 1'b0;
                o_ready  <= 1'b0;
                o_err    <= 1'b0;
            end else if (capture) begin
                state   <= DONE;
                cnt     <= '0;
                o_done  <= 1'b0 | 1'b1;
                o_ready <= 1'b1;
                o_mode  <= i_mode;
                o_speed <= i_speed;
                o_level <= (i_level > MAX_L) ? MAX_L : i_level;
                o_err   <= i_level > MAX_L;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= ARMED;
                        o_active <= 1'b1;
                    end
                    ARMED: if (i_start) begin
                        state <= HOLD;
                        cnt   <= CNT_W'(1);
                    end
                    HOLD: begin
                        state <= i_start ? HOLD : ARMED;
                        cnt   <= i_start ? cnt + 1'b1 : '0;
                    end
                    DONE: if (i_ack) begin
                        state   <= i_start ? RELEASE : ARMED;
                        o_ready <= 1'b0;
                        o_err   <= 1'b0;
                    end
                    RELEASE: if (!i_start) state <= ARMED;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_idle_setup_ctrl.sv
// tb_idle_setup_ctrl: vector table plus hand sequences, checked through an expectation queue.
module tb_idle_setup_ctrl;
    logic       clk = 1'b0;
    logic       rst, en, start, ack;
    logic [1:0] mode, level, speed;
    logic       o_active, o_ready, o_done, o_err;
    logic [1:0] o_mode, o_level, o_speed;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         tag;
        logic       rst, en, st, ack;
        logic [1:0] m, l, s;
        logic [10:0] exp;
    } vec_t;

    vec_t exp_q[$];
    vec_t cur;
    vec_t tbl[28];

    idle_setup_ctrl #(.MODE_W(2), .LEVEL_W(2), .SPEED_W(2), .START_HOLD(4), .MAX_LEVEL(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_start(start),
        .i_mode(mode), .i_level(level), .i_speed(speed), .i_ack(ack),
        .o_active(o_active), .o_ready(o_ready), .o_done(o_done),
        .o_mode(o_mode), .o_level(o_level), .o_speed(o_speed), .o_err(o_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int tag, input logic r, e, st, a, input logic [1:0] m, l, s,
                                input logic xa, xr, xd, xe, input logic [1:0] xm, xl, xs);
        vec_t v;
        v.tag = tag; v.rst = r; v.en = e; v.st = st; v.ack = a; v.m = m; v.l = l; v.s = s;
        v.exp = {xa, xr, xd, xe, xm, xl, xs};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; en = v.en; start = v.st; ack = v.ack;
        mode = v.m; level = v.l; speed = v.s;
        exp_q.push_back(v);
    endtask

    // Outputs are registered, so each vector's expectation is checked just after the following edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if ({o_active, o_ready, o_done, o_err, o_mode, o_level, o_speed} !== cur.exp) begin
                errors++;
                $display("FAIL step%0d: got a/r/d/e/m/l/s=%b/%b/%b/%b/%0d/%0d/%0d want %b/%b/%b/%b/%0d/%0d/%0d",
                         cur.tag, o_active, o_ready, o_done, o_err, o_mode, o_level, o_speed,
                         cur.exp[10], cur.exp[9], cur.exp[8], cur.exp[7],
                         cur.exp[6:5], cur.exp[4:3], cur.exp[2:1-1+0]);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; ack = 1'b0; mode = '0; level = '0; speed = '0;
        //            tag r e s a  m  l  s   a r d e  m  l  s
        tbl[0]  = mk( 0, 1,1,1,1, 3, 3, 3,  0,0,0,0, 0, 0, 0);
        tbl[1]  = mk( 1, 0,1,0,0, 2, 1, 3,  1,0,0,0, 0, 0, 0);
        tbl[2]  = mk( 2, 0,1,1,0, 2, 1, 3,  1,0,0,0, 0, 0, 0);
        tbl[3]  = mk( 3, 0,1,1,0, 2, 1, 3,  1,0,0,0, 0, 0, 0);
        tbl[4]  = mk( 4, 0,1,1,0, 2, 1, 3,  1,0,0,0, 0, 0, 0);
        tbl[5]  = mk( 5, 0,1,1,0, 2, 1, 3,  1,1,1,0, 2, 1, 3);
        tbl[6]  = mk( 6, 0,1,1,0, 1, 0, 0,  1,1,0,0, 2, 1, 3);
        tbl[7]  = mk( 7, 0,1,0,1, 1, 0, 0,  1,0,0,0, 2, 1, 3);
        tbl[8]  = mk( 8, 0,1,1,0, 1, 3, 2,  1,0,0,0, 2, 1, 3);
        tbl[9]  = mk( 9, 0,1,1,0, 1, 3, 2,  1,0,0,0, 2, 1, 3);
        tbl[10] = mk(10, 0,1,1,0, 1, 3, 2,  1,0,0,0, 2, 1, 3);
        tbl[11] = mk(11, 0,1,0,0, 1, 3, 2,  1,0,0,0, 2, 1, 3);
        tbl[12] = mk(12, 0,1,1,0, 1, 3, 2,  1,0,0,0, 2, 1, 3);
        tbl[13] = mk(13, 0,1,1,0, 1, 3, 2,  1,0,0,0, 2, 1, 3);
        tbl[14] = mk(14, 0,1,1,0, 1, 3, 2,  1,0,0,0, 2, 1, 3);
        tbl[15] = mk(15, 0,1,1,0, 1, 3, 2,  1,1,1,1, 1, 2, 2);
        tbl[16] = mk(16, 0,1,1,1, 3, 0, 1,  1,0,0,0, 1, 2, 2);
        tbl[17] = mk(17, 0,1,1,0, 3, 0, 1,  1,0,0,0, 1, 2, 2);
        tbl[18] = mk(18, 0,1,1,0, 3, 0, 1,  1,0,0,0, 1, 2, 2);
        tbl[19] = mk(19, 0,1,1,0, 3, 0, 1,  1,0,0,0, 1, 2, 2);
        tbl[20] = mk(20, 0,1,1,0, 3, 0, 1,  1,0,0,0, 1, 2, 2);
        tbl[21] = mk(21, 0,1,0,0, 3, 0, 1,  1,0,0,0, 1, 2, 2);
        tbl[22] = mk(22, 0,1,1,0, 3, 0, 1,  1,0,0,0, 1, 2, 2);
        tbl[23] = mk(23, 0,1,1,0, 3, 0, 1,  1,0,0,0, 1, 2, 2);
        tbl[24] = mk(24, 0,1,1,0, 3, 0, 1,  1,0,0,0, 1, 2, 2);
        tbl[25] = mk(25, 0,1,1,0, 3, 0, 1,  1,1,1,0, 3, 0, 1);
        tbl[26] = mk(26, 0,0,1,1, 0, 0, 0,  0,0,0,0, 3, 0, 1);
        tbl[27] = mk(27, 0,1,0,0, 0, 0, 0,  1,0,0,0, 3, 0, 1);
        for (int i = 0; i < 28; i++) apply(tbl[i]);
        // Reset in the middle of HOLD, then a full-length start with level exactly at the limit.
        apply(mk(100, 0,1,1,0, 1, 2, 0,  1,0,0,0, 3, 0, 1));
        apply(mk(101, 0,1,1,0, 1, 2, 0,  1,0,0,0, 3, 0, 1));
        apply(mk(102, 1,1,1,1, 1, 2, 0,  0,0,0,0, 0, 0, 0));
        apply(mk(103, 0,1,1,0, 1, 2, 0,  1,0,0,0, 0, 0, 0));
        apply(mk(104, 0,1,1,0, 1, 2, 0,  1,0,0,0, 0, 0, 0));
        apply(mk(105, 0,1,1,0, 1, 2, 0,  1,0,0,0, 0, 0, 0));
        apply(mk(106, 0,1,1,0, 1, 2, 0,  1,0,0,0, 0, 0, 0));
        apply(mk(107, 0,1,1,0, 1, 2, 0,  1,1,1,0, 1, 2, 0));
        // Clamped capture, then disable in DONE: ready/err drop, captured settings stay.
        apply(mk(108, 0,1,0,1, 0, 0, 0,  1,0,0,0, 1, 2, 0));
        apply(mk(109, 0,1,1,0, 2, 3, 1,  1,0,0,0, 1, 2, 0));
        apply(mk(110, 0,1,1,0, 2, 3, 1,  1,0,0,0, 1, 2, 0));
        apply(mk(111, 0,1,1,0, 2, 3, 1,  1,0,0,0, 1, 2, 0));
        apply(mk(112, 0,1,1,0, 2, 3, 1,  1,1,1,1, 2, 2, 1));
        apply(mk(113, 0,0,0,0, 0, 0, 0,  0,0,0,0, 2, 2, 1));
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/idle_setup_ctrl.md
IDLE_SETUP_CTRL -- requirements
Module: idle_setup_ctrl

Interface
REQ-001 Parameter MODE_W, default 2, width of mode field.
REQ-002 Parameter LEVEL_W, default 2, width of level field.
REQ-003 Parameter SPEED_W, default 2, width of speed field.
REQ-004 Parameter START_HOLD, default 4, consecutive i_start-high samples required to accept start; legal range >= 1.
REQ-005 Parameter MAX_LEVEL, default 3, highest legal level; legal range 0 .. 2**LEVEL_W-1.
REQ-006 i_clk  in  1  system clock; all state updates on rising edge; one clock.
REQ-007 i_rst  in  1  reset; synchronous and active-high.
REQ-008 i_enable  in  1  block enable, active-high.
REQ-009 i_start  in  1  start request, active-high level.
REQ-010 i_mode  in  MODE_W  requested game mode.
REQ-011 i_level  in  LEVEL_W  requested level.
REQ-012 i_speed  in  SPEED_W  requested speed.
REQ-013 i_ack  in  1  consumer acknowledge of captured settings.
REQ-014 o_active  out  1  high in every state except IDLE.
REQ-015 o_ready  out  1  captured settings valid; high throughout DONE.
REQ-016 o_done  out  1  single-cycle pulse on the cycle DONE is entered.
REQ-017 o_mode / o_level / o_speed  out  MODE_W / LEVEL_W / SPEED_W  captured settings.
REQ-018 o_err  out  1  captured level was clamped; valid while o_ready high.

Function
REQ-019 States: IDLE, ARMED, HOLD, DONE, RELEASE; all outputs registered.
REQ-020 Any state, i_enable=0 -> IDLE next cycle; priority over every other transition, including i_ack and i_start.
REQ-021 IDLE: i_enable=1 -> ARMED.
REQ-022 ARMED: i_start=1 -> HOLD with hold counter = 1; if START_HOLD=1, -> DONE directly with capture.
REQ-023 HOLD: i_start=1 and counter = START_HOLD-1 -> DONE with capture; i_start=1 otherwise -> counter+1; i_start=0 -> ARMED, counter cleared.
REQ-024 Hold counter width clog2(START_HOLD+1); never wraps.
REQ-025 Latency: with i_start high at N=START_HOLD consecutive edges starting in ARMED, o_done/o_ready visible after edge N.
REQ-026 Capture samples i_mode, i_level, i_speed on the same edge that enters DONE; outputs stay constant until the next capture or reset.
REQ-027 Capture: i_level > MAX_LEVEL -> o_level = MAX_LEVEL, o_err=1; otherwise o_level = i_level, o_err=0.
REQ-028 DONE: o_ready=1; i_ack=1 -> RELEASE if i_start=1, else ARMED; o_ready and o_err clear on leaving DONE.
REQ-029 RELEASE: waits for i_start=0 -> ARMED; prevents retrigger from a held start.
REQ-030 Input changes on i_mode/i_level/i_speed outside the capture edge have no effect on outputs.
REQ-031 Disable in DONE drops o_ready and o_err; captured o_mode/o_level/o_speed are retained.

Reset
REQ-032 i_rst=1 on an edge -> state IDLE, counter 0, o_active/o_ready/o_done/o_err=0, o_mode/o_level/o_speed=0.
REQ-033 Reset takes priority over i_enable, i_start, and i_ack, and takes effect mid-HOLD or mid-DONE without completing capture.

Verification (START_HOLD=4, MAX_LEVEL=2, widths 2)
REQ-034 Setup: enable=1, mode=2, level=1, speed=3, start high 4 edges -> o_done pulse 1 cycle after edge 4, o_ready=1, outputs 2/1/3, o_err=0.
REQ-035 Glitch: start high 3 edges then low -> back to ARMED, no o_done; then start high 4 edges -> o_done.
REQ-036 Clamp: level=3 at capture -> o_level=2, o_err=1; i_ack -> o_err=0, o_ready=0.
REQ-037 Held start: i_ack while start still high -> RELEASE, no second o_done until start low then 4 high edges.
REQ-038 Priority: i_enable=0 and i_ack=1 together in DONE -> IDLE, o_active=0, o_ready=0, o_mode retained.
REQ-039 Reset mid-HOLD (counter=2) -> all outputs 0 next cycle; subsequent start needs full 4 edges.
